// File: rtl/fwd_hazard_ctrl_if.sv
// Bundle between the ID-stage decode side and the forwarding/hazard
// controller: instruction tags in, mux selects and stall requests out.
interface fwd_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_reg_write;
    logic                  id_mem_read;
    logic                  flush;
    logic                  stall;
    logic                  ex_bubble;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;

    // Pipeline side: presents the decoded instruction, consumes selects/stalls
    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        input  stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    // Controller side
    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read, flush,
        output stall, ex_bubble, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller. Shadows the register tags of
// the instructions in EX, MEM and WB and drives the EX operand mux selects,
// the one-cycle load-use stall and the ID/EX bubble request. No datapath.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic             clk,
    input logic             rst_n,
    fwd_hazard_ctrl_if.slave bus
);

    // EX stage tags
    logic                  ex_v_q,   ex_v_d;
    logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
    logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
    logic [REG_ADDR_W-1:0] ex_rd_q,  ex_rd_d;
    logic                  ex_rw_q,  ex_rw_d;
    logic                  ex_mr_q,  ex_mr_d;
    // MEM stage tags
    logic                  mem_v_q,  mem_v_d;
    logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
    logic                  mem_rw_q, mem_rw_d;
    logic                  mem_mr_q, mem_mr_d;
    // WB stage tags
    logic                  wb_v_q,   wb_v_d;
    logic [REG_ADDR_W-1:0] wb_rd_q,  wb_rd_d;
    logic                  wb_rw_q,  wb_rw_d;
    // Performance counter
    logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

    logic       load_use;
    logic       stall_int;
    logic       bubble_int;
    logic       mem_a_hit, mem_b_hit, wb_a_hit, wb_b_hit;
    logic [1:0] fwd_a_sel_int, fwd_b_sel_int;

    // Load-use detection; a flush kills the consumer so it wins over the stall,
    // and both requests are held low while reset is asserted
    always_comb begin
        load_use   = bus.id_valid & ex_v_q & ex_mr_q & (ex_rd_q != '0) &
                     ((ex_rd_q == bus.id_rs1) | (ex_rd_q == bus.id_rs2));
        stall_int  = load_use & ~bus.flush & rst_n;
        bubble_int = (load_use | bus.flush) & rst_n;
    end

    // Next tag state: tags shift down the pipe, EX takes ID or a cleared bubble
    always_comb begin
        wb_v_d   = mem_v_q;
        wb_rd_d  = mem_rd_q;
        wb_rw_d  = mem_rw_q;
        mem_v_d  = ex_v_q;
        mem_rd_d = ex_rd_q;
        mem_rw_d = ex_rw_q;
        mem_mr_d = ex_mr_q;
        ex_v_d   = 1'b0;
        ex_rs1_d = '0;
        ex_rs2_d = '0;
        ex_rd_d  = '0;
        ex_rw_d  = 1'b0;
        ex_mr_d  = 1'b0;
        if (!bubble_int) begin
            ex_v_d   = bus.id_valid;
            ex_rs1_d = bus.id_rs1;
            ex_rs2_d = bus.id_rs2;
            ex_rd_d  = bus.id_rd;
            ex_rw_d  = bus.id_reg_write;
            ex_mr_d  = bus.id_mem_read;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall_int && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Tag and counter registers; reset drops every in-flight tag immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v_q      <= 1'b0;
            ex_rs1_q    <= '0;
            ex_rs2_q    <= '0;
            ex_rd_q     <= '0;
            ex_rw_q     <= 1'b0;
            ex_mr_q     <= 1'b0;
            mem_v_q     <= 1'b0;
            mem_rd_q    <= '0;
            mem_rw_q    <= 1'b0;
            mem_mr_q    <= 1'b0;
            wb_v_q      <= 1'b0;
            wb_rd_q     <= '0;
            wb_rw_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            ex_v_q      <= ex_v_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
            ex_rd_q     <= ex_rd_d;
            ex_rw_q     <= ex_rw_d;
            ex_mr_q     <= ex_mr_d;
            mem_v_q     <= mem_v_d;
            mem_rd_q    <= mem_rd_d;
            mem_rw_q    <= mem_rw_d;
            mem_mr_q    <= mem_mr_d;
            wb_v_q      <= wb_v_d;
            wb_rd_q     <= wb_rd_d;
            wb_rw_q     <= wb_rw_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Operand forwarding: youngest producer (MEM) beats WB, loads in MEM
    // have no data yet, and register 0 is never forwarded
    always_comb begin
        mem_a_hit = mem_v_q & mem_rw_q & ~mem_mr_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs1_q);
        mem_b_hit = mem_v_q & mem_rw_q & ~mem_mr_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs2_q);
        wb_a_hit  = wb_v_q & wb_rw_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs1_q);
        wb_b_hit  = wb_v_q & wb_rw_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs2_q);
        fwd_a_sel_int = 2'b00;
        fwd_b_sel_int = 2'b00;
        if (ex_v_q) begin
            if (mem_a_hit) begin
                fwd_a_sel_int = 2'b10;
            end else if (wb_a_hit) begin
                fwd_a_sel_int = 2'b01;
            end
            if (mem_b_hit) begin
                fwd_b_sel_int = 2'b10;
            end else if (wb_b_hit) begin
                fwd_b_sel_int = 2'b01;
            end
        end
    end

    assign bus.stall     = stall_int;
    assign bus.ex_bubble = bubble_int;
    assign bus.fwd_a_sel = fwd_a_sel_int;
    assign bus.fwd_b_sel = fwd_b_sel_int;
    assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Testbench for fwd_hazard_ctrl. Two instances share one stimulus stream:
// a 16-bit counter build and a 2-bit counter build for saturation. Expected
// responses come from an instruction-level pipeline model and are queued;
// a monitor process pops them and compares against the outputs each cycle.
module tb_fwd_hazard_ctrl;

    typedef struct {
        bit v;
        int rs1;
        int rs2;
        int rd;
        bit rw;
        bit mr;
    } instr_t;

    typedef struct {
        bit stall;
        bit bubble;
        int sel_a;
        int sel_b;
        int cnt16;
        int cnt2;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic id_reg_write = 1'b0, id_mem_read = 1'b0, flush = 1'b0;

    int compared = 0;
    int mismatched = 0;

    exp_t   exp_q[$];
    instr_t m_ex, m_mem, m_wb;
    instr_t nop_i;
    int     n_stalls = 0;
    bit     last_stall = 0;
    instr_t last_id;

    // Free-running pipeline clock
    always #5 clk = ~clk;

    fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(16)) bus16 ();
    fwd_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(2))  bus2 ();

    assign bus16.id_valid     = id_valid;
    assign bus16.id_rs1       = id_rs1;
    assign bus16.id_rs2       = id_rs2;
    assign bus16.id_rd        = id_rd;
    assign bus16.id_reg_write = id_reg_write;
    assign bus16.id_mem_read  = id_mem_read;
    assign bus16.flush        = flush;
    assign bus2.id_valid      = id_valid;
    assign bus2.id_rs1        = id_rs1;
    assign bus2.id_rs2        = id_rs2;
    assign bus2.id_rd         = id_rd;
    assign bus2.id_reg_write  = id_reg_write;
    assign bus2.id_mem_read   = id_mem_read;
    assign bus2.flush         = flush;

    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
    fwd_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));

    function automatic instr_t mk(bit v, int rs1, int rs2, int rd, bit rw, bit mr);
        instr_t i;
        i.v = v; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    // Which older instruction supplies register src to the one in EX:
    // 2 = the one in MEM, 1 = the one in WB, 0 = register file
    function automatic int model_sel(int src);
        if (!m_ex.v || src == 0) return 0;
        if (m_mem.v && m_mem.rw && m_mem.rd == src) begin
            if (m_mem.mr) begin
                $display("[TB] FAIL illegal_load_in_mem: reg %0d, required no load producer in MEM", src);
                mismatched++;
            end else begin
                return 2;
            end
        end
        if (m_wb.v && m_wb.rw && m_wb.rd == src) return 1;
        return 0;
    endfunction

    // A consumer in ID of a load sitting in EX must wait, unless it is being flushed
    function automatic bit model_stall(instr_t id, bit fl);
        return id.v && m_ex.v && m_ex.mr && m_ex.rd != 0 &&
               (m_ex.rd == id.rs1 || m_ex.rd == id.rs2) && !fl;
    endfunction

    function automatic int min_int(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int required);
        compared++;
        if (actual != required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, required, $time);
        end
    endtask

    task automatic modelReset();
        m_ex = nop_i; m_mem = nop_i; m_wb = nop_i;
        n_stalls = 0;
        last_stall = 0;
    endtask

    // Drive one ID slot for one cycle, queue the expected response, advance the model
    task automatic applyStimulus(input instr_t id, input bit fl);
        exp_t e;
        @(negedge clk);
        id_valid     = id.v;
        id_rs1       = 5'(id.rs1);
        id_rs2       = 5'(id.rs2);
        id_rd        = 5'(id.rd);
        id_reg_write = id.rw;
        id_mem_read  = id.mr;
        flush        = fl;
        e.stall  = model_stall(id, fl);
        e.bubble = e.stall || fl;
        e.sel_a  = model_sel(m_ex.rs1);
        e.sel_b  = model_sel(m_ex.rs2);
        e.cnt16  = min_int(n_stalls, 65535);
        e.cnt2   = min_int(n_stalls, 3);
        exp_q.push_back(e);
        if (e.stall) n_stalls++;
        m_wb  = m_mem;
        m_mem = m_ex;
        m_ex  = e.bubble ? nop_i : id;
        last_stall = e.stall;
        last_id    = id;
    endtask

    // Reset pulse between edges while tags are live
    task automatic asyncResetPulse();
        @(negedge clk);
        id_valid = 1'b0;
        flush    = 1'b0;
        #3;
        checkOutput("pre_reset_sel_a", int'(bus16.fwd_a_sel), model_sel(m_ex.rs1));
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_sel_a", int'(bus16.fwd_a_sel), 0);
        checkOutput("async_reset_sel_b", int'(bus16.fwd_b_sel), 0);
        checkOutput("async_reset_stall", int'(bus16.stall), 0);
        checkOutput("async_reset_cnt", int'(bus16.stall_cnt), 0);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Monitor: pops one expectation per cycle, sampling well after the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("stall", int'(bus16.stall), int'(e.stall));
                checkOutput("ex_bubble", int'(bus16.ex_bubble), int'(e.bubble));
                checkOutput("fwd_a_sel", int'(bus16.fwd_a_sel), e.sel_a);
                checkOutput("fwd_b_sel", int'(bus16.fwd_b_sel), e.sel_b);
                checkOutput("stall_cnt16", int'(bus16.stall_cnt), e.cnt16);
                checkOutput("stall_cnt2", int'(bus2.stall_cnt), e.cnt2);
                checkOutput("fwd_a_sel_w2", int'(bus2.fwd_a_sel), e.sel_a);
            end
        end
    end

    // Directed sequences followed by constrained-random traffic
    initial begin
        instr_t r;
        bit     fl;
        nop_i = mk(0, 0, 0, 0, 0, 0);
        modelReset();
        last_id = nop_i;

        // Reset held, flush asserted: outputs must all stay quiet
        rst_n = 1'b0;
        flush = 1'b1;
        #12;
        checkOutput("reset_stall", int'(bus16.stall), 0);
        checkOutput("reset_bubble", int'(bus16.ex_bubble), 0);
        checkOutput("reset_sel_a", int'(bus16.fwd_a_sel), 0);
        checkOutput("reset_sel_b", int'(bus16.fwd_b_sel), 0);
        checkOutput("reset_cnt", int'(bus16.stall_cnt), 0);
        flush = 1'b0;
        rst_n = 1'b1;

        // Idle
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // EX/MEM forward: ADD r3=r1+r2; SUB r5=r3-r4
        applyStimulus(mk(1, 1, 2, 3, 1, 0), 0);
        applyStimulus(mk(1, 3, 4, 5, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Priority: ADD r3, ADD r3, OR r6=r3,r3
        applyStimulus(mk(1, 1, 2, 3, 1, 0), 0);
        applyStimulus(mk(1, 4, 5, 3, 1, 0), 0);
        applyStimulus(mk(1, 3, 3, 6, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // MEM/WB forward: ADD r3, NOP, OR r6=r3,r3
        applyStimulus(mk(1, 1, 2, 3, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(mk(1, 3, 3, 6, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Load-use: LW r7; ADD r8=r7+r1 (held in ID one extra cycle)
        applyStimulus(mk(1, 2, 0, 7, 1, 1), 0);
        applyStimulus(mk(1, 7, 1, 8, 1, 0), 0);
        applyStimulus(mk(1, 7, 1, 8, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Register 0 never forwarded
        applyStimulus(mk(1, 1, 2, 0, 1, 0), 0);
        applyStimulus(mk(1, 0, 0, 9, 1, 0), 0);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Flush beats load-use
        applyStimulus(mk(1, 2, 0, 7, 1, 1), 0);
        applyStimulus(mk(1, 7, 7, 8, 1, 0), 1);
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Async reset with live tags
        applyStimulus(mk(1, 1, 2, 3, 1, 0), 0);
        applyStimulus(mk(1, 3, 4, 5, 1, 0), 0);
        asyncResetPulse();
        applyStimulus(nop_i, 0);

        // Five load-use stalls: the 2-bit counter must stick at 3
        for (int k = 0; k < 5; k++) begin
            applyStimulus(mk(1, 2, 0, 7, 1, 1), 0);
            applyStimulus(mk(1, 1, 7, 8, 1, 0), 0);
            applyStimulus(mk(1, 1, 7, 8, 1, 0), 0);
        end
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Random traffic on a small register set to provoke hazards
        for (int n = 0; n < 2000; n++) begin
            fl = m_ex.v && ($urandom_range(7) == 0);
            if (last_stall) begin
                r = last_id;
            end else begin
                r.v   = ($urandom_range(7) != 0);
                r.rs1 = int'($urandom_range(7));
                r.rs2 = int'($urandom_range(7));
                r.rd  = int'($urandom_range(7));
                r.mr  = ($urandom_range(3) == 0);
                r.rw  = r.mr || ($urandom_range(3) != 0);
            end
            applyStimulus(r, fl);
        end
        applyStimulus(nop_i, 0);
        applyStimulus(nop_i, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #3;
        if (exp_q.size() > 0) begin
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Control-side partner of the pipeline's 32-bit 2:1 / 3:1 operand muxes. This block drives their select lines.
- Tracks register tags of the instructions in EX, MEM and WB.
- Generates EX-stage operand forwarding selects and the load-use stall / bubble request.
- Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and carries no datapath.

Parameters:
- REG_ADDR_W, 5: register-index width.
- CNT_W, 16: width of the saturating stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_ADDR_W  ID source register 1
- id_rs2  in  REG_ADDR_W  ID source register 2
- id_rd  in  REG_ADDR_W  ID destination register
- id_reg_write  in  1  ID instruction writes rd
- id_mem_read  in  1  ID instruction is a load
- flush  in  1  branch taken in EX; kill the instruction in ID
- stall  out  1  hold PC and IF/ID this cycle
- ex_bubble  out  1  ID/EX must load a NOP next edge
- fwd_a_sel  out  2  EX operand A mux select: 00 regfile, 10 EX/MEM result, 01 MEM/WB result
- fwd_b_sel  out  2  EX operand B mux select, same encoding
- stall_cnt  out  CNT_W  count of load-use stall cycles, saturating

Behaviour:
Internal tag registers:
- EX: {v, rs1, rs2, rd, rw, mr}
- MEM: {v, rd, rw, mr}
- WB: {v, rd, rw}

Reset (rst_n low, asynchronous):
- All v, rw and mr bits = 0; tag indices = 0; stall_cnt = 0.
- Outputs while reset is held: stall = 0, ex_bubble = 0, fwd_a_sel = fwd_b_sel = 00.
- Reset asserted mid-operation discards every in-flight tag immediately, with no wait for a clock edge.

Load-use stall (combinational):
- stall = id_valid & EX.v & EX.mr & (EX.rd != 0) & (EX.rd == id_rs1 | EX.rd == id_rs2) & ~flush.
- ex_bubble = stall | flush.

Tag advance, each rising edge:
- WB <= MEM; MEM <= EX.
- If ex_bubble = 1: EX.v <= 0. Other EX fields are don't-care, but implementation holds them at 0.
- Otherwise: EX <= {id_valid, id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read}.
- A stall lasts exactly 1 cycle per load-use pair. On the next cycle the load is in MEM, so the stall condition clears.

Forwarding (combinational from registered tags), per operand X in {A: EX.rs1, B: EX.rs2}:
- MEM hit = MEM.v & MEM.rw & ~MEM.mr & (MEM.rd != 0) & (MEM.rd == X).
- WB hit = WB.v & WB.rw & (WB.rd != 0) & (WB.rd == X).
- sel = 10 if MEM hit; else 01 if WB hit; else 00. MEM has priority (youngest producer wins).
- Load in MEM matching X: no MEM hit. This case cannot occur after a correct stall, so it is asserted as illegal in verification.
- EX.v = 0: both selects = 00.

Register 0:
- Never forwarded and never stalled on, regardless of rw.

Simultaneous events:
- flush and a load-use condition in the same cycle: flush wins. stall = 0, ex_bubble = 1, and stall_cnt does not increment.

stall_cnt:
- Increments by 1 on each edge where stall = 1.
- Holds at 2^CNT_W - 1; no wrap-around.

Latency:
- Selects and stall are valid in the same cycle as the tags. No added pipeline delay.

Test Plan:
1. Reset and idle: drive rst_n low, then release with id_valid = 0 -> stall = 0, ex_bubble = 0, both selects 00, stall_cnt = 0.
2. EX/MEM forward: issue ADD r3 = r1 + r2, then SUB r5 = r3 - r4 -> in the cycle SUB is in EX, fwd_a_sel = 10 and fwd_b_sel = 00.
3. MEM/WB forward with priority:
   - Sequence ADD r3, ADD r3, OR r6 = r3, r3 -> when OR is in EX, both selects = 10 (younger producer wins).
   - Sequence ADD r3, NOP, OR r6 = r3, r3 -> both selects = 01.
4. Load-use:
   - Issue LW r7, then ADD r8 = r7 + r1 -> stall = 1 and ex_bubble = 1 for exactly one cycle, stall_cnt goes from 0 to 1.
   - Next cycle, with ADD in EX -> fwd_a_sel = 01.
5. Register 0 and flush:
   - ADD r0 followed by a consumer of r0 -> selects stay 00.
   - LW r7 followed by a consumer of r7, with flush = 1 in the hazard cycle -> stall = 0, ex_bubble = 1, stall_cnt unchanged.
6. Async reset and saturation:
   - Pulse rst_n low between edges while tags are valid -> selects drop to 00 at once.
   - With CNT_W = 2, force 5 stalls -> stall_cnt = 3.
